// File: rtl/spi_rx_buffer.sv
// SPI receiver in the clk domain: synchronised sclk/cs/mosi, MSB-first byte assembly, DEPTH-byte FIFO.
// Byte visible SYNC_STAGES+2 edges after the 8th sclk fall; full FIFO drops bytes (sticky overflow); SPI_RX_FRAME_CHECK_EN adds frame_err.
module spi_rx_buffer #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       cs,
  input  logic                       mosi,
  output logic [7:0]                 dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
`ifdef SPI_RX_FRAME_CHECK_EN
  ,
  output logic                       frame_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, prime_q;
  logic                   sclk_s, cs_s, mosi_s, sclk_d_q, fall, primed;
  logic                   armed_q, armed_d;

  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             shift_q, shift_d;
  logic                   push_q, push_d;
  logic [7:0]             byte_q, byte_d;
`ifdef SPI_RX_FRAME_CHECK_EN
  logic                   frame_err_q, frame_err_d;
`endif

  logic [7:0]             mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, used;
  logic                   full, empty, pop, wr_en;
  logic                   overflow_q, overflow_d;

  // All three lines use the same depth so mosi stays aligned with the sclk edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      prime_q     <= '0;
      sclk_d_q    <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      prime_q     <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      sclk_d_q    <= sclk_s;
      armed_q     <= armed_d;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign fall   = !sclk_s && sclk_d_q;
  assign primed = prime_q[SYNC_STAGES-1];

  // The cs reset value is not a real observation; arm only on cs high seen after the synchroniser has flushed.
  assign armed_d = armed_q || (primed && cs_s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      push_q      <= 1'b0;
      byte_q      <= 8'h00;
`ifdef SPI_RX_FRAME_CHECK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      byte_q      <= byte_d;
`ifdef SPI_RX_FRAME_CHECK_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    byte_d      = byte_q;
`ifdef SPI_RX_FRAME_CHECK_EN
    frame_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (armed_q && !cs_s) begin
          state_d   = RECV;
          bit_cnt_d = 3'd0;
          shift_d   = 7'd0;
        end
      end
      RECV: begin
        // cs release wins over a coincident sclk fall.
        if (cs_s) begin
          state_d     = IDLE;
          bit_cnt_d   = 3'd0;
          shift_d     = 7'd0;
`ifdef SPI_RX_FRAME_CHECK_EN
          frame_err_d = (bit_cnt_q != 3'd0);
`endif
        end else if (fall) begin
          shift_d   = {shift_q[5:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            push_d = 1'b1;
            byte_d = {shift_q, mosi_s};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign used  = wr_ptr_q - rd_ptr_q;
  assign full  = (used == PW'(DEPTH));
  assign empty = (used == '0);
  assign pop   = !empty && dout_ready;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign wr_en = push_q && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_q && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= byte_q;
    end
  end

  assign dout       = mem_q[rd_ptr_q[AW-1:0]];
  assign dout_valid = !empty;
  assign level      = LW'(used);
  assign overflow   = overflow_q;
`ifdef SPI_RX_FRAME_CHECK_EN
  assign frame_err  = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_rx_buffer.sv
// Directed bench for spi_rx_buffer: pin-level SPI/FIFO reference model checked every cycle, plus literal expectations.
module tb_spi_rx_buffer;
  localparam int DEPTH = 4;
  localparam int S     = 2;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int HALF  = S + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sclk = 1'b0;
  logic          cs = 1'b1;
  logic          mosi = 1'b0;
  logic          dout_ready = 1'b0;
  logic [7:0]    dout;
  logic          dout_valid;
  logic [LW-1:0] level;
  logic          overflow;
`ifdef SPI_RX_FRAME_CHECK_EN
  logic          frame_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_rx_buffer #(.DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .level     (level),
    .overflow  (overflow)
`ifdef SPI_RX_FRAME_CHECK_EN
    ,
    .frame_err (frame_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (pin-level view) ----------------
  logic [7:0] mq[$];
  logic [7:0] pq_b[$];
  int         pq_e[$];
  int         ferr_e[$];
  int         cyc = 0;
  bit         m_ovf = 0, m_ferr = 0, armed = 0, active = 0;
  int         nbits = 0;
  logic [7:0] sh = 8'h00;
  logic       sclk_prev = 1'b0;

  always @(posedge clk) begin
    cyc++;
    m_ferr = 0;
    if (!rst) begin
      mq.delete(); pq_b.delete(); pq_e.delete(); ferr_e.delete();
      m_ovf = 0; armed = 0; active = 0; nbits = 0; sh = 8'h00; sclk_prev = 1'b0;
    end else begin
      if (mq.size() > 0 && dout_ready) void'(mq.pop_front());
      if (ferr_e.size() > 0 && ferr_e[0] == cyc) begin
        void'(ferr_e.pop_front());
        m_ferr = 1;
      end
      if (pq_e.size() > 0 && pq_e[0] == cyc) begin
        void'(pq_e.pop_front());
        if (mq.size() < DEPTH) mq.push_back(pq_b.pop_front());
        else begin
          void'(pq_b.pop_front());
          m_ovf = 1;
        end
      end
      if (cs) begin
        armed = 1;
        if (active && nbits != 0) ferr_e.push_back(cyc + S);
        active = 0; nbits = 0; sh = 8'h00;
      end else if (active) begin
        if (sclk_prev && !sclk) begin
          sh = {sh[6:0], mosi};
          nbits++;
          if (nbits == 8) begin
            pq_e.push_back(cyc + S + 1);
            pq_b.push_back(sh);
            nbits = 0;
          end
        end
      end else if (armed) begin
        active = 1; nbits = 0;
      end
      sclk_prev = sclk;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("rst_dout", dout, 8'h00);
      check("rst_valid", dout_valid, 0);
      check("rst_level", level, 0);
      check("rst_overflow", overflow, 0);
`ifdef SPI_RX_FRAME_CHECK_EN
      check("rst_frame_err", frame_err, 0);
`endif
    end else begin
      check("cyc_valid", dout_valid, (mq.size() > 0) ? 1 : 0);
      check("cyc_level", level, mq.size());
      check("cyc_overflow", overflow, m_ovf);
      if (mq.size() > 0) check("cyc_dout", dout, mq[0]);
`ifdef SPI_RX_FRAME_CHECK_EN
      check("cyc_frame_err", frame_err, m_ferr);
`endif
    end
  end

  // ---------------- observation of pops and error pulses ----------------
  logic [7:0] popped[$];
  int         ferr_cnt = 0;

  always @(negedge clk) begin
    if (rst && dout_valid && dout_ready) popped.push_back(dout);
`ifdef SPI_RX_FRAME_CHECK_EN
    if (rst && frame_err) ferr_cnt++;
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, input bit pop_last);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      sclk = 1'b1;
      repeat (HALF) tick();
      sclk = 1'b0;
      for (int w = 1; w <= HALF; w++) begin
        tick();
        if (pop_last && i == n - 1) begin
          if (w == S + 1) dout_ready = 1'b1;
          else if (w == S + 2) dout_ready = 1'b0;
        end
      end
    end
  endtask

  task automatic cs_on();
    cs = 1'b0;
    repeat (HALF) tick();
  endtask

  task automatic cs_off();
    cs = 1'b1;
    repeat (3 * HALF) tick();
  endtask

  task automatic drain();
    int t;
    t = 0;
    dout_ready = 1'b1;
    while (level != 0 && t < 50) begin
      tick();
      t++;
    end
    dout_ready = 1'b0;
    check("drain_timeout", (t >= 50) ? 1 : 0, 0);
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t3 [5];
    t3[0] = 8'h01; t3[1] = 8'h02; t3[2] = 8'h03; t3[3] = 8'h04; t3[4] = 8'h05;

    repeat (4) tick();
    rst = 1'b1;
    repeat (4) tick();

    // single byte, consumer always ready
    popped.delete();
    dout_ready = 1'b1;
    cs_on(); spi_bits(8'hEF, 8, 0); cs_off();
    dout_ready = 1'b0;
    check("t1_npop", popped.size(), 1);
    check("t1_byte", popped[0], 8'hEF);
    check("t1_level", level, 0);

    // three bytes in one frame, then drain
    popped.delete();
    cs_on(); spi_bits(8'hA5, 8, 0); spi_bits(8'h3C, 8, 0); spi_bits(8'hFF, 8, 0); cs_off();
    check("t2_level", level, 3);
    drain();
    check("t2_npop", popped.size(), 3);
    check("t2_pop0", popped[0], 8'hA5);
    check("t2_pop1", popped[1], 8'h3C);
    check("t2_pop2", popped[2], 8'hFF);

    // overflow: fifth byte dropped
    popped.delete();
    cs_on();
    for (int i = 0; i < 5; i++) spi_bits(t3[i], 8, 0);
    cs_off();
    check("t3_level", level, 4);
    check("t3_overflow", overflow, 1);
    drain();
    check("t3_npop", popped.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_pop", popped[i], t3[i]);
    check("t3_overflow_sticky", overflow, 1);

    // full FIFO, push coincides with pop
    popped.delete();
    cs_on();
    spi_bits(8'h10, 8, 0); spi_bits(8'h11, 8, 0); spi_bits(8'h12, 8, 0); spi_bits(8'h13, 8, 0);
    spi_bits(8'h77, 8, 1);
    cs_off();
    check("t4_level", level, 4);
    drain();
    check("t4_npop", popped.size(), 5);
    check("t4_first", popped[0], 8'h10);
    check("t4_last", popped[4], 8'h77);

    // truncated frame then full byte
    ferr_cnt = 0;
    cs_on(); spi_bits(8'hB6, 5, 0); cs_off();
    cs_on(); spi_bits(8'h81, 8, 0); cs_off();
    check("t5_level", level, 1);
    check("t5_dout", dout, 8'h81);
`ifdef SPI_RX_FRAME_CHECK_EN
    check("t5_frame_err_pulses", ferr_cnt, 1);
`endif

    // reset mid-frame, then a frame with cs never raised must be ignored
    cs_on(); spi_bits(8'hC3, 4, 0);
    rst = 1'b0;
    repeat (3) tick();
    check("t6_rst_level", level, 0);
    check("t6_rst_valid", dout_valid, 0);
    check("t6_rst_overflow", overflow, 0);
    check("t6_rst_dout", dout, 8'h00);
    rst = 1'b1;
    repeat (2) tick();
    spi_bits(8'hA5, 8, 0);
    repeat (3 * HALF) tick();
    check("t6_unarmed_level", level, 0);
    cs_off();
    cs_on(); spi_bits(8'h5A, 8, 0); cs_off();
    check("t6_level", level, 1);
    check("t6_dout", dout, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
